num_sweep_controller: RTL and testbench
=======================================

Name: num_sweep_controller

Overview:
- Sequencer that drives the 5-bit number input of the num_detector datapath through 0..31.
- Sweeps either automatically at a prescaled rate or one value per step pulse.
- Samples the detector's five LED outputs once per value and accumulates a per-LED hit count.
- Sits between the board push-buttons/switches and num_detector; hit counts feed display logic.

Parameters:
- TICK_DIV, 50_000_000, clk cycles between values in auto mode; must be >= 3.
- CNT_W, 6, width of each per-LED hit counter; must be >= 6 so the value 32 fits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  synchronous one-cycle pulse: begin sweep.
- stop  input  1  synchronous one-cycle pulse: abort sweep.
- step  input  1  synchronous one-cycle pulse: advance one value (manual mode only).
- mode_auto  input  1  1 = auto sweep, 0 = manual step; latched on accepted start.
- led_in  input  5  LED1..LED5 from num_detector (bit0 = LED1).
- cnt_sel  input  3  selects counter 0..4 for hit_count; values 5..7 select zero.
- number  output  5  value presented to num_detector.
- busy  output  1  high in SETTLE, SAMPLE, WAIT.
- done  output  1  high after a complete sweep until next accepted start.
- hit_count  output  CNT_W  selected LED hit counter, combinational mux of registered counters.

Behaviour:
- Reset (async, rst_n=0): state IDLE, number=0, busy=0, done=0, all counters=0, prescaler=0, mode latch=0.
- States: IDLE, SETTLE, SAMPLE, WAIT, DONE.
- IDLE/DONE + start (stop=0):
  - Latch mode_auto; number<=0; clear all counters and prescaler; done<=0.
  - Next state SETTLE.
- SETTLE: exactly 1 cycle, gives the combinational detector time to settle; -> SAMPLE.
- SAMPLE: exactly 1 cycle.
  - For each i with led_in[i]=1, counter[i]<=counter[i]+1.
  - If number==31: -> DONE, done<=1.
  - Otherwise: -> WAIT, prescaler<=0.
- WAIT, auto mode:
  - Prescaler counts every cycle.
  - In the cycle prescaler==TICK_DIV-3: number<=number+1, -> SETTLE.
  - Result: value period is exactly TICK_DIV cycles (SETTLE+SAMPLE+WAIT).
- WAIT, manual mode: on step: number<=number+1, -> SETTLE. The prescaler is unused.
- number holds its value until the next increment; no wrap occurs inside a sweep (31 terminates).
- stop in SETTLE/SAMPLE/WAIT:
  - -> IDLE next cycle; done stays 0.
  - number and counters are retained.
  - A SAMPLE-cycle stop still applies that cycle's counter update.
- stop in IDLE/DONE: no effect; done is unchanged.
- start and stop in the same cycle: stop wins; from IDLE/DONE nothing happens.
- start while busy: ignored.
- step while busy in auto mode, in SETTLE/SAMPLE, or in IDLE/DONE: ignored, not queued.
- mode_auto changes mid-sweep: ignored until the next accepted start.
- Counters never exceed 32 per sweep and saturate at 2^CNT_W-1 regardless.
- Latency: start to first sample = 2 cycles (start edge -> SETTLE -> SAMPLE).
- Full auto sweep from accepted start to done=1: 31*TICK_DIV + 2 cycles.
- Reset mid-sweep: immediate return to reset values.

Test Plan:
- Auto sweep, TICK_DIV=4, led_in driven by a bench model that sets led_in=5'b00001 when number is odd:
  - number steps 0..31, one value per 4 cycles.
  - done=1 exactly 126 cycles after start.
  - cnt_sel=0 gives hit_count=16; cnt_sel=1..4 give 0.
- Manual mode, mode_auto=0, led_in=5'b11111:
  - 3 step pulses after start give number=3.
  - With cnt_sel=4, hit_count reads 1 after the first sample, then 2, 3, 4 after successive steps.
  - busy=1, done=0 throughout.
- Stop mid-sweep (auto, TICK_DIV=4) issued while number=10:
  - IDLE next cycle; number stays 10; busy=0, done=0.
  - Counters frozen.
  - A following start resets number to 0 and clears counters.
- Simultaneous start+stop in IDLE: state stays IDLE, busy=0, number unchanged. Step pulses in auto mode: number cadence unaffected.
- Async reset asserted mid-WAIT (not aligned to clk): number=0, busy=0, done=0, all hit counts 0 immediately. cnt_sel=5..7 read 0 at all times.

Source files
------------

// File: rtl/num_sweep_controller_if.sv
// Handshake bundle between board controls / num_detector and the sweep controller.
// master = stimulus side (buttons, detector LEDs, display select); slave = controller.
interface num_sweep_controller_if #(
  parameter int CNT_W = 6
);
  logic             start;
  logic             stop;
  logic             step;
  logic             mode_auto;
  logic [4:0]       led_in;
  logic [2:0]       cnt_sel;
  logic [4:0]       number;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output start, stop, step, mode_auto, led_in, cnt_sel,
    input  number, busy, done, hit_count
  );

  modport slave (
    input  start, stop, step, mode_auto, led_in, cnt_sel,
    output number, busy, done, hit_count
  );
endinterface

// File: rtl/num_sweep_controller.sv
// Sweeps num_detector's number input 0..31 and counts per-LED hits, auto-prescaled or stepped.
// Latency: start to first sample 2 cycles; auto value period TICK_DIV; start/step/stop are pulses.
// Backpressure: none; pulses arriving in states that cannot act on them are dropped, not queued.
module num_sweep_controller #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  num_sweep_controller_if.slave sif
);

  localparam int PW = (TICK_DIV > 4) ? $clog2(TICK_DIV) : 2;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [4:0]       number_q;
  logic             busy_q;
  logic             done_q;
  logic             mode_q;
  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] cnt [5];
  logic [CNT_W-1:0] hit_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      number_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= 1'b0;
      presc    <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // stop dominates start; stop alone here leaves done untouched
          if (sif.start && !sif.stop) begin
            mode_q   <= sif.mode_auto;
            number_q <= '0;
            presc    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
            state    <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (sif.stop) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            state  <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          for (int i = 0; i < 5; i++) begin
            if (sif.led_in[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
          end
          if (sif.stop) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (number_q == 5'd31) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            presc  <= '0;
            state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (sif.stop) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (mode_q) begin
            // SETTLE + SAMPLE + (TICK_DIV-2) WAIT cycles = TICK_DIV per value
            if (presc == PRESC_LAST) begin
              number_q <= number_q + 5'd1;
              state    <= S_SETTLE;
            end else begin
              presc    <= presc + 1'b1;
            end
          end else if (sif.step) begin
            number_q <= number_q + 5'd1;
            state    <= S_SETTLE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    hit_sel = '0;
    case (sif.cnt_sel)
      3'd0:    hit_sel = cnt[0];
      3'd1:    hit_sel = cnt[1];
      3'd2:    hit_sel = cnt[2];
      3'd3:    hit_sel = cnt[3];
      3'd4:    hit_sel = cnt[4];
      default: hit_sel = '0;
    endcase
  end

  assign sif.number    = number_q;
  assign sif.busy      = busy_q;
  assign sif.done      = done_q;
  assign sif.hit_count = hit_sel;

endmodule

// File: tb/tb_num_sweep_controller.sv
// Directed bench for num_sweep_controller with a scoreboard of expected per-cycle outputs.
module tb_num_sweep_controller;

  localparam int TD = 4;

  typedef struct packed {
    logic [4:0] num;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst_n;
  logic led_all;
  int   total;
  int   bad;
  exp_t sbq[$];
  int   hitq[$];

  num_sweep_controller_if #(.CNT_W(6)) sif ();

  num_sweep_controller #(.TICK_DIV(TD), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Detector stand-in: LED1 lit on odd numbers, or all LEDs lit
  always_comb begin
    sif.led_in = led_all ? 5'h1f : {4'b0000, sif.number[0]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_hit(input string tag, input logic [2:0] sel, input int exp);
    sif.cnt_sel = sel;
    #1;
    chk(tag, 32'(sif.hit_count), exp);
  endtask

  initial begin
    exp_t e;
    int   guard;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    led_all       = 1'b0;
    sif.start     = 1'b0;
    sif.stop      = 1'b0;
    sif.step      = 1'b0;
    sif.mode_auto = 1'b0;
    sif.cnt_sel   = 3'd0;

    // Reset state
    ticks(2);
    chk("rst_number", 32'(sif.number), 0);
    chk("rst_busy", 32'(sif.busy), 0);
    chk("rst_done", 32'(sif.done), 0);
    for (int s = 0; s < 8; s++) chk_hit("rst_hit", 3'(s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(2);

    // Auto sweep: per-cycle scoreboard from start edge to done
    for (int k = 0; k <= 31 * TD + 2; k++) begin
      e.num  = (k / TD > 31) ? 5'd31 : 5'(k / TD);
      e.busy = (k < 31 * TD + 2);
      e.done = (k == 31 * TD + 2);
      sbq.push_back(e);
    end
    sif.mode_auto = 1'b1;
    sif.start     = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 31 * TD + 2; k++) begin
      @(negedge clk);
      sif.start = (k == 20);
      sif.step  = (k == 10) || (k == 33) || (k == 34) || (k == 70);
      if (k == 2) sif.mode_auto = 1'b0;
      e = sbq.pop_front();
      chk($sformatf("auto_num_k%0d", k), 32'(sif.number), 32'(e.num));
      chk($sformatf("auto_busy_k%0d", k), 32'(sif.busy), 32'(e.busy));
      chk($sformatf("auto_done_k%0d", k), 32'(sif.done), 32'(e.done));
    end
    sif.start = 1'b0;
    sif.step  = 1'b0;
    chk("sb_empty", 32'(sbq.size()), 0);
    chk_hit("auto_hit0", 3'd0, 16);
    for (int s = 1; s < 8; s++) chk_hit($sformatf("auto_hit%0d", s), 3'(s), 0);

    // stop in DONE leaves done high
    @(negedge clk);
    sif.stop = 1'b1;
    @(negedge clk);
    sif.stop = 1'b0;
    chk("done_stop_done", 32'(sif.done), 1);
    chk("done_stop_busy", 32'(sif.busy), 0);

    // Manual mode with all LEDs lit; mode_auto flip after start must be ignored
    led_all       = 1'b1;
    sif.mode_auto = 1'b0;
    sif.start     = 1'b1;
    hitq.push_back(1);
    @(negedge clk);
    sif.start     = 1'b0;
    sif.mode_auto = 1'b1;
    ticks(6);
    chk("man_num0", 32'(sif.number), 0);
    chk("man_busy0", 32'(sif.busy), 1);
    chk("man_done0", 32'(sif.done), 0);
    chk_hit("man_hit4_0", 3'd4, hitq.pop_front());
    for (int i = 1; i <= 3; i++) begin
      hitq.push_back(i + 1);
      sif.step = 1'b1;
      @(negedge clk);
      sif.step = 1'b0;
      ticks(2 * TD);
      chk($sformatf("man_num%0d", i), 32'(sif.number), i);
      chk($sformatf("man_busy%0d", i), 32'(sif.busy), 1);
      chk($sformatf("man_done%0d", i), 32'(sif.done), 0);
      chk_hit($sformatf("man_hit4_%0d", i), 3'd4, hitq.pop_front());
    end
    chk_hit("man_hit0", 3'd0, 4);
    sif.stop = 1'b1;
    @(negedge clk);
    sif.stop = 1'b0;
    chk("man_stop_busy", 32'(sif.busy), 0);
    chk("man_stop_num", 32'(sif.number), 3);

    // Stop mid auto sweep at number 10
    led_all       = 1'b0;
    sif.mode_auto = 1'b1;
    sif.start     = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    guard = 0;
    while (sif.number != 5'd10 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_n10_timeout", 32'(guard < 200), 1);
    sif.stop = 1'b1;
    @(negedge clk);
    sif.stop = 1'b0;
    chk("stop_busy", 32'(sif.busy), 0);
    chk("stop_done", 32'(sif.done), 0);
    chk("stop_num", 32'(sif.number), 10);
    chk_hit("stop_hit0", 3'd0, 5);
    sif.step = 1'b1;
    @(negedge clk);
    sif.step = 1'b0;
    ticks(2 * TD);
    chk("frozen_num", 32'(sif.number), 10);
    chk_hit("frozen_hit0", 3'd0, 5);

    // start+stop together in IDLE does nothing
    sif.start = 1'b1;
    sif.stop  = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    sif.stop  = 1'b0;
    ticks(2);
    chk("ss_busy", 32'(sif.busy), 0);
    chk("ss_num", 32'(sif.number), 10);
    chk_hit("ss_hit0", 3'd0, 5);

    // Restart clears number and counters
    sif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    chk("restart_num", 32'(sif.number), 0);
    chk("restart_busy", 32'(sif.busy), 1);
    chk_hit("restart_hit0", 3'd0, 0);

    // Run into WAIT of value 3, then async reset off the clock edge
    ticks(3 * TD + 2);
    chk("pre_rst_num", 32'(sif.number), 3);
    chk_hit("pre_rst_hit0", 3'd0, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_num", 32'(sif.number), 0);
    chk("arst_busy", 32'(sif.busy), 0);
    chk("arst_done", 32'(sif.done), 0);
    for (int s = 0; s < 8; s++) chk_hit($sformatf("arst_hit%0d", s), 3'(s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(2);
    chk("post_rst_busy", 32'(sif.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
